// File: rtl/e_mdu_if.sv
// Operand, control and result bundle between the Execute stage and the
// multiply/divide unit.
interface e_mdu_if;
   logic        start;
   logic [3:0]  MDUOp;
   logic        Req;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, MDUOp, Req, A, B, input busy, HI, LO);
   modport slave  (input start, MDUOp, Req, A, B, output busy, HI, LO);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// The result is computed at accept time and committed when the countdown expires.
module e_mdu #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input logic    clk,
   input logic    reset,
   e_mdu_if.slave bus
);

   logic [31:0]        hi_q, lo_q, hi_tmp, lo_tmp;
   logic [31:0]        res_hi, res_lo;
   logic [3:0]         cnt, cnt_ld;
   logic               idle, accept, is_md;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;

   assign idle   = (cnt == 4'd0) && !bus.Req;
   assign is_md  = (bus.MDUOp >= 4'd1) && (bus.MDUOp <= 4'd4);
   assign accept = idle && bus.start && is_md;

   assign bus.busy = (cnt != 4'd0);
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

   always_comb begin
      // Divide by zero re-commits the current HI/LO; they cannot change while busy.
      res_hi = hi_q;
      res_lo = lo_q;
      cnt_ld = 4'(MULT_CYC);
      prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
      prod_u = {32'd0, bus.A} * {32'd0, bus.B};
      case (bus.MDUOp)
         4'd1: {res_hi, res_lo} = prod_s;
         4'd2: {res_hi, res_lo} = prod_u;
         4'd3: begin
            cnt_ld = 4'(DIV_CYC);
            if (bus.B == 32'd0) begin
               res_hi = hi_q;
            end else if ((bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF)) begin
               // The one signed quotient that overflows wraps to itself.
               res_lo = 32'h8000_0000;
               res_hi = 32'd0;
            end else begin
               res_lo = $signed(bus.A) / $signed(bus.B);
               res_hi = $signed(bus.A) % $signed(bus.B);
            end
         end
         4'd4: begin
            cnt_ld = 4'(DIV_CYC);
            if (bus.B != 32'd0) begin
               res_lo = bus.A / bus.B;
               res_hi = bus.A % bus.B;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         hi_tmp <= 32'd0;
         lo_tmp <= 32'd0;
         cnt    <= 4'd0;
      end else if (cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            hi_q <= hi_tmp;
            lo_q <= lo_tmp;
         end
      end else if (accept) begin
         hi_tmp <= res_hi;
         lo_tmp <= res_lo;
         cnt    <= cnt_ld;
      end else if (idle && (bus.MDUOp == 4'd5)) begin
         hi_q <= bus.A;
      end else if (idle && (bus.MDUOp == 4'd6)) begin
         lo_q <= bus.A;
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Directed table plus randomized run of e_mdu against an arithmetic reference model.
module tb_e_mdu;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   e_mdu_if bus ();

   e_mdu #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      int          rep;
      bit          rst;
      bit          st;
      logic [3:0]  op;
      bit          req;
      logic [31:0] a;
      logic [31:0] b;
      bit          ebusy;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nmis = 0;

   // reference model: deadline-based, results from plain 64-bit arithmetic
   longint      edge_n = 0;
   longint      deadline = 0;
   logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
   bit          p_skip = 0;

   function automatic void model_edge(bit rst, bit st, logic [3:0] op, bit req,
                                      logic [31:0] a, logic [31:0] b);
      bit busy_pre;
      longint sp, q, r;
      longint unsigned up;
      edge_n++;
      if (rst) begin
         m_hi = 0; m_lo = 0; deadline = 0;
         return;
      end
      busy_pre = (edge_n - 1) < deadline;
      if (edge_n == deadline && !p_skip) begin
         m_hi = p_hi; m_lo = p_lo;
      end
      if (busy_pre || req) return;
      if (st && op >= 1 && op <= 4) begin
         p_skip = 0;
         case (op)
            1: begin
               sp = longint'($signed(a)) * longint'($signed(b));
               p_hi = sp[63:32]; p_lo = sp[31:0];
            end
            2: begin
               up = longint'({32'd0, a}) * longint'({32'd0, b});
               p_hi = up[63:32]; p_lo = up[31:0];
            end
            3: if (b == 0) p_skip = 1;
               else begin
                  q = longint'($signed(a)) / longint'($signed(b));
                  r = longint'($signed(a)) % longint'($signed(b));
                  p_lo = q[31:0]; p_hi = r[31:0];
               end
            default: if (b == 0) p_skip = 1;
               else begin
                  p_lo = a / b; p_hi = a % b;
               end
         endcase
         deadline = edge_n + ((op <= 2) ? MULT_CYC : DIV_CYC);
      end else if (op == 5) m_hi = a;
      else if (op == 6) m_lo = a;
   endfunction

   function automatic bit model_busy();
      return edge_n < deadline;
   endfunction

   task automatic check(string name, bit eb, logic [31:0] eh, logic [31:0] el);
      nvec++;
      if (bus.busy !== eb || bus.HI !== eh || bus.LO !== el) begin
         nmis++;
         $display("FAIL %s @%0t: got busy=%0b HI=%08h LO=%08h, want busy=%0b HI=%08h LO=%08h",
                  name, $time, bus.busy, bus.HI, bus.LO, eb, eh, el);
      end
   endtask

   // called at a negedge: drive, take the edge, sample at the next negedge
   task automatic step(bit rst, bit st, logic [3:0] op, bit req, logic [31:0] a, logic [31:0] b);
      reset = rst; bus.start = st; bus.MDUOp = op; bus.Req = req; bus.A = a; bus.B = b;
      @(posedge clk);
      model_edge(rst, st, op, req, a, b);
      @(negedge clk);
   endtask

   function automatic void add(int rep, bit rst, bit st, logic [3:0] op, bit req,
                               logic [31:0] a, logic [31:0] b,
                               bit eb, logic [31:0] eh, logic [31:0] el);
      vec_t v;
      v.rep = rep; v.rst = rst; v.st = st; v.op = op; v.req = req; v.a = a; v.b = b;
      v.ebusy = eb; v.ehi = eh; v.elo = el;
      tbl.push_back(v);
   endfunction

   initial begin
      reset = 1'b1; bus.start = 0; bus.MDUOp = 0; bus.Req = 0; bus.A = 0; bus.B = 0;

      // reset
      add(2, 1, 0, 0, 0, 0, 0,                       0, 32'h0, 32'h0);
      // mult -1 * 2
      add(1, 0, 1, 1, 0, 32'hFFFF_FFFF, 2,           1, 32'h0, 32'h0);
      add(4, 0, 0, 0, 0, 0, 0,                       1, 32'h0, 32'h0);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      // multu same operands
      add(1, 0, 1, 2, 0, 32'hFFFF_FFFF, 2,           1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      add(4, 0, 0, 0, 0, 0, 0,                       1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'h1, 32'hFFFF_FFFE);
      // div -7 / 2
      add(1, 0, 1, 3, 0, 32'hFFFF_FFF9, 2,           1, 32'h1, 32'hFFFF_FFFE);
      add(9, 0, 0, 0, 0, 0, 0,                       1, 32'h1, 32'hFFFF_FFFE);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      // divu 7 / 2
      add(1, 0, 1, 4, 0, 7, 2,                       1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      add(9, 0, 0, 0, 0, 0, 0,                       1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'h1, 32'h3);
      // signed overflow
      add(1, 0, 1, 3, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h1, 32'h3);
      add(9, 0, 0, 0, 0, 0, 0,                       1, 32'h1, 32'h3);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'h0, 32'h8000_0000);
      // mtlo, mthi, divide by zero
      add(1, 0, 0, 6, 0, 32'h1234, 0,                0, 32'h0, 32'h1234);
      add(1, 0, 0, 5, 0, 32'h5678, 0,                0, 32'h5678, 32'h1234);
      add(1, 0, 1, 3, 0, 9, 0,                       1, 32'h5678, 32'h1234);
      add(9, 0, 0, 0, 0, 0, 0,                       1, 32'h5678, 32'h1234);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'h5678, 32'h1234);
      // second start and mthi during busy are ignored
      add(1, 0, 1, 1, 0, 3, 4,                       1, 32'h5678, 32'h1234);
      add(1, 0, 1, 1, 0, 5, 5,                       1, 32'h5678, 32'h1234);
      add(1, 0, 0, 5, 0, 32'hAAAA, 0,                1, 32'h5678, 32'h1234);
      add(2, 0, 0, 0, 0, 0, 0,                       1, 32'h5678, 32'h1234);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'h0, 32'hC);
      // Req blocks start and mthi
      add(1, 0, 1, 1, 1, 7, 7,                       0, 32'h0, 32'hC);
      add(1, 0, 0, 5, 1, 32'hFF, 0,                  0, 32'h0, 32'hC);
      // Req while busy does not cancel
      add(1, 0, 1, 2, 0, 10, 10,                     1, 32'h0, 32'hC);
      add(4, 0, 0, 0, 1, 0, 0,                       1, 32'h0, 32'hC);
      add(1, 0, 0, 0, 1, 0, 0,                       0, 32'h0, 32'h64);
      // back-to-back
      add(1, 0, 1, 1, 0, 2, 3,                       1, 32'h0, 32'h64);
      add(4, 0, 0, 0, 0, 0, 0,                       1, 32'h0, 32'h64);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'h0, 32'h6);
      add(1, 0, 1, 1, 0, 4, 5,                       1, 32'h0, 32'h6);
      add(4, 0, 0, 0, 0, 0, 0,                       1, 32'h0, 32'h6);
      add(1, 0, 0, 0, 0, 0, 0,                       0, 32'h0, 32'h14);
      // reset in busy's third cycle discards the result
      add(1, 0, 1, 1, 0, 3, 3,                       1, 32'h0, 32'h14);
      add(2, 0, 0, 0, 0, 0, 0,                       1, 32'h0, 32'h14);
      add(1, 1, 0, 0, 0, 0, 0,                       0, 32'h0, 32'h0);
      add(6, 0, 0, 0, 0, 0, 0,                       0, 32'h0, 32'h0);

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].rep; k++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].op, tbl[i].req, tbl[i].a, tbl[i].b);
            check($sformatf("dir%0d.%0d", i, k), tbl[i].ebusy, tbl[i].ehi, tbl[i].elo);
         end
      end

      // randomized traffic against the model
      step(1, 0, 0, 0, 0, 0);
      check("rnd_reset", model_busy(), m_hi, m_lo);
      for (int n = 0; n < 3000; n++) begin
         bit rst, st, req;
         logic [3:0] op;
         logic [31:0] a, b;
         rst = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 9) < 7);
         req = ($urandom_range(0, 9) == 0);
         op  = 4'($urandom_range(0, 8));
         a   = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 9));
            default: b = $urandom;
         endcase
         step(rst, st, op, req, a, b);
         check($sformatf("rnd%0d", n), model_busy(), m_hi, m_lo);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
